// File: rtl/regfile_access_ctrl_pkg.sv
// Shared widths and FSM encoding for the register-file access controller.
// Also holds the index helper used by its sub-blocks.
package regfile_access_ctrl_pkg;

  localparam int RF_XLEN  = 32;
  localparam int IDX_W    = 5;
  localparam int STARVE_W = 4;

  typedef logic [IDX_W-1:0] idx_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_LAT   = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // x0 is hardwired to zero, so a write to it never needs a port-A slot.
  function automatic logic idx_is_zero(input idx_t idx);
    return (idx == '0);
  endfunction

endpackage

// File: rtl/regfile_op_capture.sv
// Operand capture register: loads both read operands on capture_i.
// Holds them, with valid, until the consumer accepts them.
module regfile_op_capture
  import regfile_access_ctrl_pkg::*;
#(
  parameter int XLEN = RF_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            op_ready_i,
  output logic            op_valid_o,
  output logic [XLEN-1:0] op_rs1_o,
  output logic [XLEN-1:0] op_rs2_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;

  always_comb begin
    valid_d = valid_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (capture_i) begin
      valid_d = 1'b1;
      rs1_d   = rs1_i;
      rs2_d   = rs2_i;
    end else if (op_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign op_valid_o = valid_q;
  assign op_rs1_o   = rs1_q;
  assign op_rs2_o   = rs2_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: arbitrates writeback against operand reads on shared port A,
// sequences the 1-cycle read latency and hands operands to execute via valid/ready.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int XLEN       = RF_XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [IDX_W-1:0] wb_rdi,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [IDX_W-1:0] rd_req_rs1i,
  input  logic [IDX_W-1:0] rd_req_rs2i,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [XLEN-1:0]  op_rs1,
  output logic [XLEN-1:0]  op_rs2,
  output logic [XLEN-1:0]  rf_rd,
  output logic [IDX_W-1:0] rf_rdi,
  output logic             rf_rdw_rsrn,
  output logic [IDX_W-1:0] rf_rs1i,
  output logic [IDX_W-1:0] rf_rs2i,
  input  logic [XLEN-1:0]  rf_rs1,
  input  logic [XLEN-1:0]  rf_rs2
);

  logic [1:0]          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                rdw_q, rdw_d;
  logic [IDX_W-1:0]    rdi_q, rdi_d;
  logic [XLEN-1:0]     rd_q, rd_d;
  logic [IDX_W-1:0]    rs1i_q, rs1i_d;
  logic [IDX_W-1:0]    rs2i_q, rs2i_d;

  logic arb_slot;
  logic read_can;
  logic starve_force;
  logic wb_hs;
  logic rd_hs;
  logic wr_slot;
  logic capture;

  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] v);
    return (v == {STARVE_W{1'b1}}) ? v : v + STARVE_W'(1);
  endfunction

  // Port A is free for a new slot only once the previous read has been captured.
  assign arb_slot     = (state_q == ST_IDLE) || (state_q == ST_OUT);
  assign read_can     = (state_q == ST_IDLE) || ((state_q == ST_OUT) && op_ready);
  assign starve_force = (starve_q >= STARVE_W'(STARVE_MAX));

  assign wb_ready     = arb_slot && !(starve_force && rd_req_valid && read_can);
  assign rd_req_ready = read_can && (!wb_valid || starve_force);

  assign wb_hs   = wb_valid && wb_ready;
  assign rd_hs   = rd_req_valid && rd_req_ready;
  assign wr_slot = wb_hs && !idx_is_zero(wb_rdi);
  assign capture = (state_q == ST_LAT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (rd_hs) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_LAT;
      ST_LAT:   state_d = ST_OUT;
      ST_OUT:   if (op_ready) state_d = rd_hs ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (rd_hs) begin
      starve_d = '0;
    end else if (rd_req_valid && read_can && wb_valid) begin
      starve_d = starve_inc(starve_q);
    end
  end

  // Write slot and read indexes are launched one cycle after their handshake.
  always_comb begin
    rdw_d  = wr_slot;
    rdi_d  = rdi_q;
    rd_d   = rd_q;
    rs1i_d = rs1i_q;
    rs2i_d = rs2i_q;
    if (wr_slot) begin
      rdi_d = wb_rdi;
      rd_d  = wb_data;
    end
    if (rd_hs) begin
      rs1i_d = rd_req_rs1i;
      rs2i_d = rd_req_rs2i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      rdw_q    <= 1'b0;
      rdi_q    <= '0;
      rd_q     <= '0;
      rs1i_q   <= '0;
      rs2i_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rdw_q    <= rdw_d;
      rdi_q    <= rdi_d;
      rd_q     <= rd_d;
      rs1i_q   <= rs1i_d;
      rs2i_q   <= rs2i_d;
    end
  end

  assign rf_rdw_rsrn = rdw_q;
  assign rf_rdi      = rdi_q;
  assign rf_rd       = rd_q;
  assign rf_rs1i     = rs1i_q;
  assign rf_rs2i     = rs2i_q;

  regfile_op_capture #(
    .XLEN(XLEN)
  ) u_op_capture (
    .clk        (clk),
    .rst        (rst),
    .capture_i  (capture),
    .rs1_i      (rf_rs1),
    .rs2_i      (rf_rs2),
    .op_ready_i (op_ready),
    .op_valid_o (op_valid),
    .op_rs1_o   (op_rs1),
    .op_rs2_o   (op_rs2)
  );

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register file on the rf_* side.
module tb_regfile_access_ctrl;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wb_valid = 1'b0;
  logic            wb_ready;
  logic [4:0]      wb_rdi = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            rd_req_valid = 1'b0;
  logic            rd_req_ready;
  logic [4:0]      rd_req_rs1i = '0;
  logic [4:0]      rd_req_rs2i = '0;
  logic            op_valid;
  logic            op_ready = 1'b0;
  logic [XLEN-1:0] op_rs1, op_rs2;
  logic [XLEN-1:0] rf_rd;
  logic [4:0]      rf_rdi;
  logic            rf_rdw_rsrn;
  logic [4:0]      rf_rs1i, rf_rs2i;
  logic [XLEN-1:0] rf_rs1, rf_rs2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(
    .XLEN(XLEN),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rdi       (wb_rdi),
    .wb_data      (wb_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_rs1i  (rd_req_rs1i),
    .rd_req_rs2i  (rd_req_rs2i),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_rs1       (op_rs1),
    .op_rs2       (op_rs2),
    .rf_rd        (rf_rd),
    .rf_rdi       (rf_rdi),
    .rf_rdw_rsrn  (rf_rdw_rsrn),
    .rf_rs1i      (rf_rs1i),
    .rf_rs2i      (rf_rs2i),
    .rf_rs1       (rf_rs1),
    .rf_rs2       (rf_rs2)
  );

  // Register file model: x0 reads zero, read data registered one cycle after the index.
  logic [XLEN-1:0] mem [32] = '{default: '0};
  always @(posedge clk) begin
    if (rf_rdw_rsrn && rf_rdi != 5'd0) mem[rf_rdi] <= rf_rd;
    rf_rs1 <= mem[rf_rs1i];
    rf_rs2 <= mem[rf_rs2i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge where a read handshake will occur at the next posedge.
  task automatic wait_op(input logic consume, output int lat,
                         output logic [31:0] g1, output logic [31:0] g2);
    lat = 0;
    do begin
      @(negedge clk);
      rd_req_valid = 1'b0;
      lat++;
    end while (!op_valid && lat < 12);
    g1 = op_rs1;
    g2 = op_rs2;
    if (consume) begin
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
    int n;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_rdi   = idx;
    wb_data  = data;
    n = 0;
    #1;
    while (!wb_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("wb_accept_x%0d", idx), wb_ready, 1);
    @(negedge clk);
    wb_valid = 1'b0;
    check($sformatf("wr_pulse_x%0d", idx), rf_rdw_rsrn, (idx != 5'd0));
    if (idx != 5'd0) begin
      check($sformatf("wr_rdi_x%0d", idx), rf_rdi, idx);
      check($sformatf("wr_rd_x%0d", idx), rf_rd, data);
    end
    @(negedge clk);
    check($sformatf("wr_pulse_end_x%0d", idx), rf_rdw_rsrn, 0);
  endtask

  task automatic do_read(input logic [4:0] r1, input logic [4:0] r2, output int lat,
                         output logic [31:0] g1, output logic [31:0] g2);
    int n;
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req_rs1i  = r1;
    rd_req_rs2i  = r2;
    n = 0;
    #1;
    while (!rd_req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rd_accept", rd_req_ready, 1);
    wait_op(1'b1, lat, g1, g2);
  endtask

  typedef struct {
    logic        wen;
    logic [4:0]  wi;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          lat;
    int          cyc;
    logic [31:0] g1, g2;
    logic        pre_ok, hold_ok, wr_ok;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd10, 32'hA5A5A5A5, 5'd10, 5'd10, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[3] = '{1'b1, 5'd31, 32'h80000000, 5'd31, 5'd5,  32'h80000000, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h0,        32'h80000000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_rs1", op_rs1, 0);
    check("rst_op_rs2", op_rs2, 0);
    check("rst_rdw", rf_rdw_rsrn, 0);
    check("rst_rdi", rf_rdi, 0);
    check("rst_rd", rf_rd, 0);
    check("rst_rs1i", rf_rs1i, 0);
    check("rst_rs2i", rf_rs2i, 0);
    rst = 1'b1;

    // Table: optional write then read, 3-cycle latency each time
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].wen) do_write(vecs[i].wi, vecs[i].wd);
      do_read(vecs[i].r1, vecs[i].r2, lat, g1, g2);
      check($sformatf("v%0d_lat", i), lat, 3);
      check($sformatf("v%0d_rs1", i), g1, vecs[i].e1);
      check($sformatf("v%0d_rs2", i), g2, vecs[i].e2);
    end

    // Same-cycle write and read to x7: write first, read sees it
    @(negedge clk);
    wb_valid = 1'b1; wb_rdi = 5'd7; wb_data = 32'h12345678;
    rd_req_valid = 1'b1; rd_req_rs1i = 5'd7; rd_req_rs2i = 5'd0;
    #1;
    check("both_wb_ready", wb_ready, 1);
    check("both_rd_blocked", rd_req_ready, 0);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    check("both_wr_pulse", rf_rdw_rsrn, 1);
    check("both_rd_ready", rd_req_ready, 1);
    wait_op(1'b1, lat, g1, g2);
    check("both_lat", lat, 3);
    check("both_rs1", g1, 32'h12345678);

    // Starvation: continuous writes to x9, read of x9 wins on the 5th cycle
    @(negedge clk);
    wb_valid = 1'b1; wb_rdi = 5'd9;
    rd_req_valid = 1'b1; rd_req_rs1i = 5'd9; rd_req_rs2i = 5'd0;
    pre_ok = 1'b1;
    cyc = 0;
    while (cyc < 10) begin
      cyc++;
      wb_data = 32'h100 + cyc;
      #1;
      if (rd_req_ready) break;
      if (!wb_ready) pre_ok = 1'b0;
      @(negedge clk);
    end
    check("starve_cycle", cyc, 5);
    check("starve_wb_low", wb_ready, 0);
    check("starve_wb_before", pre_ok, 1);
    wb_valid = 1'b0;
    wait_op(1'b1, lat, g1, g2);
    check("starve_lat", lat, 3);
    check("starve_rs1", g1, 32'h104);
    @(negedge clk);
    #1;
    check("starve_wb_restored", wb_ready, 1);

    // Operands held while op_ready low; writes to x3 accepted during OUT
    do_write(5'd3, 32'h33);
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_rs1i = 5'd3; rd_req_rs2i = 5'd3;
    #1;
    check("hold_rd_accept", rd_req_ready, 1);
    wait_op(1'b0, lat, g1, g2);
    check("hold_lat", lat, 3);
    check("hold_first", g1, 32'h33);
    hold_ok = 1'b1;
    wr_ok   = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      wb_valid = 1'b1; wb_rdi = 5'd3; wb_data = 32'h300 + i;
      #1;
      if (!wb_ready) wr_ok = 1'b0;
      if (!op_valid || op_rs1 !== 32'h33 || op_rs2 !== 32'h33) hold_ok = 1'b0;
      @(negedge clk);
    end
    wb_valid = 1'b0;
    check("hold_stable", hold_ok, 1);
    check("hold_wr_accepted", wr_ok, 1);
    check("hold_still_valid", op_valid, 1);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check("hold_consumed", op_valid, 0);
    do_read(5'd3, 5'd0, lat, g1, g2);
    check("hold_last_write", g1, 32'h30A);

    // Reset asserted while the read is in LAT
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_rs1i = 5'd10; rd_req_rs2i = 5'd31;
    #1;
    check("lat_rd_accept", rd_req_ready, 1);
    @(negedge clk);
    rd_req_valid = 1'b0;
    check("lat_issue_rs1i", rf_rs1i, 10);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("lat_rst_op_valid", op_valid, 0);
    check("lat_rst_op_rs1", op_rs1, 0);
    check("lat_rst_rdw", rf_rdw_rsrn, 0);
    check("lat_rst_rdi", rf_rdi, 0);
    check("lat_rst_rd", rf_rd, 0);
    check("lat_rst_rs1i", rf_rs1i, 0);
    check("lat_rst_rs2i", rf_rs2i, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_op_valid", op_valid, 0);
    do_read(5'd10, 5'd31, lat, g1, g2);
    check("post_rst_lat", lat, 3);
    check("post_rst_rs1", g1, 32'hA5A5A5A5);
    check("post_rst_rs2", g2, 32'h80000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
